// File: rtl/vdp_dec_pkg.sv
// ---------------------------------------------------------------------------
// vdp_dec_pkg
//   Shared definitions for the VDP decode stage: the opcode encoding and the
//   positions of the instruction fields within the instruction word.
//   Register fields sit in 4-bit slots above the address/immediate field,
//   so their LSB positions are expressed as offsets from AW. The helper
//   functions turn those offsets into absolute bit positions for a given AW.
// ---------------------------------------------------------------------------
package vdp_dec_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_LOAD  = 3'b010,
    OP_STORE = 3'b011,
    OP_BRZ   = 3'b100,
    OP_MOV   = 3'b101,
    OP_RSVD  = 3'b110,
    OP_JUMP  = 3'b111
  } opcode_e;

  localparam int OP_W   = 3;
  localparam int RD_OFS = 0;
  localparam int RS_OFS = 4;
  localparam int OP_OFS = 8;

  function automatic int rd_lsb(input int aw);
    return aw + RD_OFS;
  endfunction

  function automatic int rs_lsb(input int aw);
    return aw + RS_OFS;
  endfunction

  function automatic int op_lsb(input int aw);
    return aw + OP_OFS;
  endfunction

endpackage

// File: rtl/vdp_sync_fifo.sv
// ---------------------------------------------------------------------------
// vdp_sync_fifo
//   Single-clock FIFO, DEPTH entries of W bits. Read and write pointers wrap
//   naturally (DEPTH is a power of two) and an occupancy count provides the
//   full/empty flags. 'clr' empties the FIFO on the next edge.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     clr             empty the FIFO (takes priority over push/pop)
//     push, wdata     write one entry (ignored when full)
//     pop             discard the head entry (ignored when empty)
//     rdata           head entry (valid when !empty)
//     full, empty     occupancy flags
// ---------------------------------------------------------------------------
module vdp_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vdp_decode_stage.sv
// ---------------------------------------------------------------------------
// vdp_decode_stage
//   Pipelined VDP instruction decoder. The accepted word (program-load
//   bypass or fetched instruction) is split into its fields and buffered in
//   a small FIFO; the head entry is decoded into a registered output stage
//   with valid/ready handshakes on both sides, a flush, and a retired count.
//   Optional feature macro: VDP_DEC_ILLEGAL_TRAP_EN
//     defined   - opcode 110 is dropped at output load and d_illegal pulses
//     undefined - opcode 110 is a NOP, presented and counted; d_illegal = 0
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     d_prog, bypass,      word select (1: bypass) and the two candidate words
//     d_inst
//     in_valid, in_ready   upstream handshake
//     flush                discard everything buffered or held
//     out_valid, out_ready downstream handshake
//     d_op, d_a, d_rs,     decoded fields
//     d_rd
//     d_add, d_jump        opcode flags
//     d_illegal            illegal-opcode pulse
//     d_count              retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module vdp_decode_stage
  import vdp_dec_pkg::*;
#(
  parameter int AW    = 16,
  parameter int RW    = 2,
  parameter int DEPTH = 2,
  parameter int CW    = 16,
  localparam int IW   = AW + 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_prog,
  input  logic [IW-1:0] bypass,
  input  logic [IW-1:0] d_inst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [2:0]    d_op,
  output logic [AW-1:0] d_a,
  output logic [RW-1:0] d_rs,
  output logic [RW-1:0] d_rd,
  output logic          d_add,
  output logic          d_jump,
  output logic          d_illegal,
  output logic [CW-1:0] d_count
);

`ifdef VDP_DEC_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int RD_LSB = rd_lsb(AW);
  localparam int RS_LSB = rs_lsb(AW);
  localparam int OP_LSB = op_lsb(AW);
  // FIFO entries carry only the decoded fields: {op, rs, rd, a}.
  localparam int FW     = OP_W + 2 * RW + AW;

  logic [IW-1:0]   sel_word;
  logic            unused_word;
  logic [FW-1:0]   push_fields;
  logic [FW-1:0]   head_fields;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [2:0]      head_op;
  logic            head_trap;

  logic            out_valid_q, out_valid_d;
  logic [2:0]      d_op_q, d_op_d;
  logic [AW-1:0]   d_a_q, d_a_d;
  logic [RW-1:0]   d_rs_q, d_rs_d;
  logic [RW-1:0]   d_rd_q, d_rd_d;
  logic            d_add_q, d_add_d;
  logic            d_jump_q, d_jump_d;
  logic            d_illegal_q, d_illegal_d;
  logic [CW-1:0]   d_count_q, d_count_d;

  // Bits outside the decoded fields are deliberately ignored.
  assign sel_word    = d_prog ? bypass : d_inst;
  assign unused_word = ^sel_word;
  assign push_fields = {sel_word[OP_LSB +: OP_W], sel_word[RS_LSB +: RW],
                        sel_word[RD_LSB +: RW], sel_word[AW-1:0]};

  // in_ready depends only on registered state, rst and flush, never on
  // out_ready, so no combinational path crosses the stage.
  assign in_ready = !rst && !fifo_full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty && (!out_valid_q || out_ready) && !flush;

  vdp_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata (push_fields),
    .rdata (head_fields),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_op   = head_fields[FW-1 -: OP_W];
  assign head_trap = TRAP_EN && (head_op == OP_RSVD);

  // Output stage: retire the presented instruction, then load the FIFO head
  // (or drop it as illegal). Flush wins over both and suppresses the count.
  always_comb begin
    out_valid_d = out_valid_q;
    d_op_d      = d_op_q;
    d_a_d       = d_a_q;
    d_rs_d      = d_rs_q;
    d_rd_d      = d_rd_q;
    d_add_d     = d_add_q;
    d_jump_d    = d_jump_q;
    d_illegal_d = 1'b0;
    d_count_d   = d_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      d_count_d   = d_count_q + CW'(1);
    end

    if (pop) begin
      if (head_trap) begin
        d_illegal_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        d_op_d      = head_op;
        d_a_d       = head_fields[AW-1:0];
        d_rd_d      = head_fields[AW +: RW];
        d_rs_d      = head_fields[AW + RW +: RW];
        d_add_d     = (head_op == OP_ADD);
        d_jump_d    = (head_op == OP_JUMP);
      end
    end

    if (flush) begin
      out_valid_d = 1'b0;
      d_illegal_d = 1'b0;
      d_count_d   = d_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      d_op_q      <= '0;
      d_a_q       <= '0;
      d_rs_q      <= '0;
      d_rd_q      <= '0;
      d_add_q     <= 1'b0;
      d_jump_q    <= 1'b0;
      d_illegal_q <= 1'b0;
      d_count_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      d_op_q      <= d_op_d;
      d_a_q       <= d_a_d;
      d_rs_q      <= d_rs_d;
      d_rd_q      <= d_rd_d;
      d_add_q     <= d_add_d;
      d_jump_q    <= d_jump_d;
      d_illegal_q <= d_illegal_d;
      d_count_q   <= d_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign d_op      = d_op_q;
  assign d_a       = d_a_q;
  assign d_rs      = d_rs_q;
  assign d_rd      = d_rd_q;
  assign d_add     = d_add_q;
  assign d_jump    = d_jump_q;
  assign d_illegal = d_illegal_q;
  assign d_count   = d_count_q;

endmodule
